// File: rtl/spread_seq_ctrl.sv
// spread_seq_ctrl
//
// Spreads each accepted data bit into CHIPS_PER_BIT chips. For each chip it
// reads an external synchronous chip ROM (one clock of read latency) and
// emits the ROM word as-is for a 0 bit or bitwise-inverted for a 1 bit.
// Exactly one bit is in flight at a time. The next bit is accepted only
// after the last chip of the current bit has been handed off.
//
// Parameters
//   CHIPS_PER_BIT : ROM entries read per data bit, legal range 1..8.
//
// Ports
//   clk_s      in   single rising-edge clock
//   rst        in   asynchronous active-high reset
//   bit_in     in   data bit to spread
//   bit_valid  in   bit_in is valid
//   bit_ready  out  block can accept a bit (high only in IDLE)
//   rom_addr   out  registered chip ROM address
//   rom_data   in   ROM word, valid one clock after rom_addr is sampled
//   chip_out   out  registered spread chip
//   chip_valid out  chip_out is valid
//   chip_ready in   downstream accepts the chip
//   chip_last  out  chip_out is the final chip of the current bit
//   bit_cnt    out  (only with SPREAD_SEQ_CNT_EN) count of completed bits
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data stable while valid is high and
// ready is low. valid never depends combinationally on ready.
//
// Optional feature: define SPREAD_SEQ_CNT_EN to add the 16-bit bit_cnt
// output. It counts last-chip handshakes and wraps from 0xFFFF to 0x0000.
module spread_seq_ctrl #(
    parameter int CHIPS_PER_BIT = 8
) (
    input  logic       clk_s,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [2:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] chip_out,
    output logic       chip_valid,
    input  logic       chip_ready,
    output logic       chip_last
`ifdef SPREAD_SEQ_CNT_EN
    ,
    output logic [15:0] bit_cnt
`endif
);

    // IDLE: waiting for a bit. READ: ROM samples rom_addr.
    // CAPT: ROM word is available and is loaded into chip_out on the exit edge.
    // HOLD: chip presented until the downstream handshake.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [2:0] LAST_ADDR = 3'(CHIPS_PER_BIT - 1);

    state_t state;
    logic   bit_lat;

    always_ff @(posedge clk_s or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_ready  <= 1'b1;
            rom_addr   <= 3'd0;
            chip_out   <= 8'h00;
            chip_valid <= 1'b0;
            chip_last  <= 1'b0;
            bit_lat    <= 1'b0;
`ifdef SPREAD_SEQ_CNT_EN
            bit_cnt    <= 16'h0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bit_valid) begin
                        bit_lat   <= bit_in;
                        rom_addr  <= 3'd0;
                        bit_ready <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    chip_out   <= bit_lat ? ~rom_data : rom_data;
                    chip_valid <= 1'b1;
                    chip_last  <= (rom_addr == LAST_ADDR);
                    state      <= HOLD;
                end
                HOLD: begin
                    if (chip_ready) begin
                        chip_valid <= 1'b0;
                        chip_last  <= 1'b0;
                        // chip_last is registered from rom_addr, so it marks
                        // the final chip without a second compare here.
                        if (chip_last) begin
                            rom_addr  <= 3'd0;
                            bit_ready <= 1'b1;
                            state     <= IDLE;
`ifdef SPREAD_SEQ_CNT_EN
                            bit_cnt   <= bit_cnt + 16'd1;
`endif
                        end else begin
                            rom_addr <= rom_addr + 3'd1;
                            state    <= READ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spread_seq_ctrl.sv
// Testbench for spread_seq_ctrl. Two instances share the stimulus: one with
// CHIPS_PER_BIT = 8 and one with CHIPS_PER_BIT = 1. Each instance has its own
// synchronous ROM that returns 0x10 + addr. A transaction-level model
// predicts the outputs and is compared on every falling edge. The directed
// tests also compare the logged chip streams against hand-written lists.
module tb_spread_seq_ctrl;

    logic       clk_s = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       chip_ready = 1'b1;

    logic [2:0] addr8, addr1;
    logic [7:0] rom8 = 8'h00, rom1 = 8'h00;
    logic [7:0] chip8, chip1;
    logic       rdy8, rdy1, val8, val1, last8, last1;
`ifdef SPREAD_SEQ_CNT_EN
    logic [15:0] cnt8, cnt1;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Clock and ROM models.
    always #5 clk_s = ~clk_s;
    always @(posedge clk_s) cyc <= cyc + 1;
    always @(posedge clk_s) begin
        rom8 <= 8'h10 + {5'b0, addr8};
        rom1 <= 8'h10 + {5'b0, addr1};
    end

    spread_seq_ctrl #(.CHIPS_PER_BIT(8)) u8 (
        .clk_s(clk_s), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(rdy8), .rom_addr(addr8), .rom_data(rom8), .chip_out(chip8),
        .chip_valid(val8), .chip_ready(chip_ready), .chip_last(last8)
`ifdef SPREAD_SEQ_CNT_EN
        , .bit_cnt(cnt8)
`endif
    );

    spread_seq_ctrl #(.CHIPS_PER_BIT(1)) u1 (
        .clk_s(clk_s), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(rdy1), .rom_addr(addr1), .rom_data(rom1), .chip_out(chip1),
        .chip_valid(val1), .chip_ready(chip_ready), .chip_last(last1)
`ifdef SPREAD_SEQ_CNT_EN
        , .bit_cnt(cnt1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int cpb_of(input int d);
        return (d == 0) ? 8 : 1;
    endfunction

    function automatic logic [7:0] exp_chip(input logic b, input int k);
        logic [7:0] v;
        v = 8'h10 + 8'(k);
        return b ? ~v : v;
    endfunction

    // Behavioural model. A bit is accepted whenever the instance is idle and
    // bit_valid is high. Each chip is presented two edges after the accept
    // or after the previous chip's handshake. The bit completes on the
    // handshake of chip CHIPS_PER_BIT-1.
    logic m_active[2];
    logic m_valid[2];
    logic m_bit[2];
    int   m_idx[2];
    int   m_wait[2];

    always @(posedge clk_s or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_active[d] = 1'b0; m_valid[d] = 1'b0; m_bit[d] = 1'b0;
                m_idx[d] = 0; m_wait[d] = 0;
            end else if (!m_active[d]) begin
                if (bit_valid) begin
                    m_active[d] = 1'b1; m_bit[d] = bit_in; m_idx[d] = 0; m_wait[d] = 2;
                end
            end else if (m_valid[d]) begin
                if (chip_ready) begin
                    m_valid[d] = 1'b0;
                    if (m_idx[d] == cpb_of(d) - 1) begin
                        m_active[d] = 1'b0; m_idx[d] = 0;
                    end else begin
                        m_idx[d] = m_idx[d] + 1; m_wait[d] = 2;
                    end
                end
            end else begin
                m_wait[d] = m_wait[d] - 1;
                if (m_wait[d] == 0) m_valid[d] = 1'b1;
            end
        end
    end

    task automatic check_dut(input int d, input logic rdy, input logic val, input logic last,
                             input logic [2:0] addr, input logic [7:0] chip);
        chk($sformatf("u%0d_bit_ready", d), rdy, !m_active[d]);
        chk($sformatf("u%0d_chip_valid", d), val, m_valid[d]);
        chk($sformatf("u%0d_chip_last", d), last, m_valid[d] && (m_idx[d] == cpb_of(d) - 1));
        chk($sformatf("u%0d_rom_addr", d), addr, m_idx[d]);
        if (m_valid[d]) chk($sformatf("u%0d_chip_out", d), chip, exp_chip(m_bit[d], m_idx[d]));
    endtask

    // Compare process plus handshake monitor ({last, chip} per transfer).
    logic [8:0] mon8[$], mon1[$];
    int         cyc8[$], cyc1[$];
    logic [8:0] exp_q[$];

    always @(negedge clk_s) begin
        check_dut(0, rdy8, val8, last8, addr8, chip8);
        check_dut(1, rdy1, val1, last1, addr1, chip1);
        if (val8 && chip_ready) begin mon8.push_back({last8, chip8}); cyc8.push_back(cyc); end
        if (val1 && chip_ready) begin mon1.push_back({last1, chip1}); cyc1.push_back(cyc); end
    end

    // Driver tasks.
    task automatic wait_cycle();
        @(posedge clk_s);
        #1;
    endtask

    task automatic clear_logs();
        mon8.delete(); mon1.delete(); cyc8.delete(); cyc1.delete(); exp_q.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (rdy8 && rdy1) break;
            wait_cycle();
        end
        if (i == budget) chk({name, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_chip8(input string name, input logic [2:0] a, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (val8 && addr8 == a) break;
            wait_cycle();
        end
        if (i == budget) chk({name, "_chip_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send_bit(input logic b);
        bit_in = b;
        bit_valid = 1'b1;
        wait_cycle();
        bit_valid = 1'b0;
    endtask

    task automatic expect_bit8(input logic b);
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7) ? 1'b1 : 1'b0, exp_chip(b, k)});
    endtask

    task automatic compare_log(input string name, input int d);
        logic [8:0] got[$];
        if (d == 0) got = mon8; else got = mon1;
        chk({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_chip%0d", name, i), got[i], exp_q[i]);
    endtask

    task automatic check_reset8(input string name);
        chk({name, "_bit_ready"}, rdy8, 1);
        chk({name, "_rom_addr"}, addr8, 0);
        chk({name, "_chip_out"}, chip8, 8'h00);
        chk({name, "_chip_valid"}, val8, 0);
        chk({name, "_chip_last"}, last8, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset values.
        repeat (3) wait_cycle();
        check_reset8("reset");
        chk("reset_u1_bit_ready", rdy1, 1);
        rst = 1'b0;
        clear_logs();

        // Bit 0: chips 0x10..0x17, three edges between handshakes.
        send_bit(1'b0);
        wait_idle("t1", 200);
        expect_bit8(1'b0);
        compare_log("t1", 0);
        for (int i = 1; i < cyc8.size(); i++) chk($sformatf("t1_gap%0d", i), cyc8[i] - cyc8[i-1], 3);
        chk("t1_last_value", mon8.size() == 8 ? mon8[7] : 9'h0, 9'h117);
        chk("t1_ready_after", rdy8, 1);

        // Bit 1: inverted chips 0xEF..0xE8.
        clear_logs();
        send_bit(1'b1);
        wait_idle("t2", 200);
        expect_bit8(1'b1);
        compare_log("t2", 0);
        chk("t2_first_value", mon8.size() > 0 ? mon8[0] : 9'h0, 9'h0EF);

        // Stall on chip 3 while a new bit is offered.
        clear_logs();
        send_bit(1'b0);
        wait_chip8("t3", 3'd3, 50);
        chip_ready = 1'b0;
        bit_in = 1'b1;
        bit_valid = 1'b1;
        repeat (5) begin
            wait_cycle();
            chk("t3_chip_out", chip8, 8'h13);
            chk("t3_chip_last", last8, 0);
            chk("t3_rom_addr", addr8, 3);
            chk("t3_bit_ready", rdy8, 0);
            chk("t3_chip_valid", val8, 1);
        end
        bit_valid = 1'b0;
        chip_ready = 1'b1;
        wait_idle("t3", 200);
        expect_bit8(1'b0);
        compare_log("t3", 0);

        // Reset while holding chip 4.
        clear_logs();
        send_bit(1'b0);
        wait_chip8("t4", 3'd4, 50);
        rst = 1'b1;
        #1;
        check_reset8("t4_async");
        chk("t4_async_u1_bit_ready", rdy1, 1);
        wait_cycle();
        rst = 1'b0;
        clear_logs();
        repeat (6) wait_cycle();
        chk("t4_no_chip5", mon8.size(), 0);
        send_bit(1'b0);
        chk("t4_restart_addr", addr8, 0);
        wait_idle("t4", 200);
        expect_bit8(1'b0);
        compare_log("t4", 0);

        // CHIPS_PER_BIT = 1: back-to-back bits 0,1,0, four edges per bit.
        wait_idle("t5_pre", 200);
        clear_logs();
        bit_in = 1'b0;
        bit_valid = 1'b1;
        wait_cycle();
        bit_in = 1'b1;
        repeat (4) wait_cycle();
        bit_in = 1'b0;
        repeat (4) wait_cycle();
        bit_valid = 1'b0;
        wait_idle("t5", 200);
        exp_q.delete();
        exp_q.push_back(9'h110);
        exp_q.push_back(9'h1EF);
        exp_q.push_back(9'h110);
        compare_log("t5", 1);
        for (int i = 1; i < cyc1.size(); i++) chk($sformatf("t5_gap%0d", i), cyc1[i] - cyc1[i-1], 4);

`ifdef SPREAD_SEQ_CNT_EN
        // Counter wrap and reset.
        wait_idle("t6_pre", 200);
        force u8.bit_cnt = 16'hFFFF;
        #1;
        release u8.bit_cnt;
        send_bit(1'b0);
        wait_idle("t6", 200);
        chk("t6_wrap", cnt8, 16'h0000);
        send_bit(1'b1);
        wait_idle("t6b", 200);
        chk("t6_one", cnt8, 16'h0001);
        rst = 1'b1;
        #1;
        chk("t6_reset", cnt8, 16'h0000);
        wait_cycle();
        rst = 1'b0;
`endif

        repeat (3) wait_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
